// File: rtl/freq_seg_display_pkg.sv
// Segment constants and display geometry shared by the 7-segment display driver.
// Patterns are active-high abcdefg with bit 0 = segment a.
package dds_disp_pkg;

    localparam int DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/freq_seg_display_if.sv
// BCD digits from the frequency meter in, multiplexed display pins out.
interface freq_seg_display_if;
    logic [3:0] thou_count;
    logic [3:0] hund_count;
    logic [3:0] ten_count;
    logic [3:0] one_count;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    modport master (
        output thou_count, hund_count, ten_count, one_count,
        input  seg, dp, an
    );

    modport slave (
        input  thou_count, hund_count, ten_count, one_count,
        output seg, dp, an
    );
endinterface

// File: rtl/freq_seg_display_bcd_to_seg.sv
// Combinational BCD to active-high 7-segment decoder; codes above 9 show a dash.
module bcd_to_seg
    import dds_disp_pkg::*;
(
    input  logic [3:0] code_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end else begin
            case (code_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/freq_seg_display.sv
// Time-multiplexed 4-digit 7-segment driver with per-frame digit latching
// and leading-zero blanking.
module freq_seg_display
    import dds_disp_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    freq_seg_display_if.slave  disp
);

    localparam int             PW      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]  PRE_TC  = PW'(REFRESH_DIV - 1);
    localparam logic [3:0]     AN_OFF  = AN_ACTIVE_LOW  ? 4'hF  : 4'h0;
    localparam logic [6:0]     SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic           DP_OFF  = SEG_ACTIVE_LOW;

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    an_q, an_d;
    logic          dp_q;

    logic          tick, wrap;
    logic [15:0]   incoming, src;
    logic [3:0]    code;
    logic          blank;
    logic [6:0]    pattern;

    assign tick     = (presc_q == PRE_TC);
    assign wrap     = tick && (idx_q == 2'd3);
    assign incoming = {disp.thou_count, disp.hund_count, disp.ten_count, disp.one_count};
    // On the wrap tick the ones slot must already reflect the newly latched reading.
    assign src      = wrap ? incoming : shadow_q;

    always_comb begin
        code  = src[3:0];
        blank = 1'b0;
        case (idx_d)
            2'd0: code = src[3:0];
            2'd1: begin
                code  = src[7:4];
                blank = (src[15:4] == 12'h000);
            end
            2'd2: begin
                code  = src[11:8];
                blank = (src[15:8] == 8'h00);
            end
            2'd3: begin
                code  = src[15:12];
                blank = (src[15:12] == 4'h0);
            end
            default: ;
        endcase
    end

    bcd_to_seg u_dec (
        .code_i  (code),
        .blank_i (blank),
        .seg_o   (pattern)
    );

    always_comb begin
        presc_d  = tick ? '0 : PW'(presc_q + 1'b1);
        idx_d    = tick ? 2'(idx_q + 2'd1) : idx_q;
        shadow_d = wrap ? incoming : shadow_q;
        seg_d    = seg_q;
        an_d     = an_q;
        if (tick) begin
            seg_d = SEG_ACTIVE_LOW ? ~pattern : pattern;
            an_d  = AN_ACTIVE_LOW ? ~(4'b0001 << idx_d) : (4'b0001 << idx_d);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q  <= '0;
            idx_q    <= 2'd0;
            shadow_q <= '0;
            seg_q    <= SEG_OFF;
            an_q     <= AN_OFF;
            dp_q     <= DP_OFF;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
            dp_q     <= DP_OFF;
        end
    end

    assign disp.seg = seg_q;
    assign disp.an  = an_q;
    assign disp.dp  = dp_q;

endmodule

// File: tb/tb_freq_seg_display.sv
// Directed bench for freq_seg_display at REFRESH_DIV=4, active-low segments and anodes.
module tb_freq_seg_display;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    freq_seg_display_if dif ();

    freq_seg_display #(
        .REFRESH_DIV    (4),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .disp (dif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic set_digits(input logic [3:0] t, input logic [3:0] h,
                              input logic [3:0] n, input logic [3:0] o);
        dif.thou_count = t;
        dif.hund_count = h;
        dif.ten_count  = n;
        dif.one_count  = o;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_an"},  {4'h0, dif.an},  8'h0F);
        chk({tag, "_seg"}, {1'b0, dif.seg}, 8'h7F);
        chk({tag, "_dp"},  {7'h0, dif.dp},  8'h01);
    endtask

    task automatic chk_slot(input string tag, input logic [3:0] an, input logic [6:0] seg);
        chk({tag, "_an"},  {4'h0, dif.an},  {4'h0, an});
        chk({tag, "_seg"}, {1'b0, dif.seg}, {1'b0, seg});
    endtask

    // Advance one full slot and sample mid-cycle; also confirm outputs held between ticks.
    task automatic slot(input string tag, input logic [3:0] an, input logic [6:0] seg);
        logic [3:0] an_prev;
        an_prev = dif.an;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({tag, "_hold"}, {4'h0, dif.an}, {4'h0, an_prev});
        @(posedge clk);
        @(negedge clk);
        chk_slot(tag, an, seg);
    endtask

    initial begin
        set_digits(4'd1, 4'd2, 4'd3, 4'd4);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("rst_held");
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk_reset("rst_release");
        end
        @(posedge clk);
        @(negedge clk);
        chk_slot("first_tens", 4'b1101, 7'h7F);

        slot("f1_hund", 4'b1011, 7'h7F);
        slot("f1_thou", 4'b0111, 7'h7F);
        slot("f2_ones", 4'b1110, 7'h19);
        slot("f2_tens", 4'b1101, 7'h30);
        slot("f2_hund", 4'b1011, 7'h24);
        slot("f2_thou", 4'b0111, 7'h79);
        slot("f3_ones", 4'b1110, 7'h19);
        slot("f3_tens", 4'b1101, 7'h30);

        // idx is 1 here: the rest of this frame must still show the old reading
        set_digits(4'd5, 4'd6, 4'd7, 4'd8);
        slot("mid_hund", 4'b1011, 7'h24);
        slot("mid_thou", 4'b0111, 7'h79);
        slot("new_ones", 4'b1110, 7'h00);
        slot("new_tens", 4'b1101, 7'h78);
        slot("new_hund", 4'b1011, 7'h02);
        slot("new_thou", 4'b0111, 7'h12);
        chk("dp_off", {7'h0, dif.dp}, 8'h01);

        set_digits(4'd0, 4'd0, 4'd0, 4'd7);
        slot("b7_ones", 4'b1110, 7'h78);
        slot("b7_tens", 4'b1101, 7'h7F);
        slot("b7_hund", 4'b1011, 7'h7F);
        slot("b7_thou", 4'b0111, 7'h7F);

        set_digits(4'd0, 4'd0, 4'd0, 4'd0);
        slot("z_ones", 4'b1110, 7'h40);
        slot("z_tens", 4'b1101, 7'h7F);
        slot("z_hund", 4'b1011, 7'h7F);
        slot("z_thou", 4'b0111, 7'h7F);

        set_digits(4'hC, 4'd0, 4'd0, 4'd0);
        slot("inv_ones", 4'b1110, 7'h40);
        slot("inv_tens", 4'b1101, 7'h40);
        slot("inv_hund", 4'b1011, 7'h40);
        slot("inv_thou", 4'b0111, 7'h3F);
        slot("inv2_ones", 4'b1110, 7'h40);
        slot("inv2_tens", 4'b1101, 7'h40);
        slot("inv2_hund", 4'b1011, 7'h40);

        // idx is 2: reset must restore idle outputs on the very next edge
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset("mid_rst");
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("mid_rst_rel");
        @(posedge clk);
        @(negedge clk);
        // shadow was cleared, so tens is blank even though it held 0 under a nonzero thousands
        chk_slot("post_rst_tens", 4'b1101, 7'h7F);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
